// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light protocol monitor:
// light encodings, error codes and the encoding legality check.
package traffic_pkg;

   typedef logic [2:0] light_t;

   localparam light_t RED = 3'b100;
   localparam light_t YEL = 3'b010;
   localparam light_t GRN = 3'b001;

   localparam int unsigned NUM_ERR    = 7;
   localparam int unsigned ERR_CODE_W = 3;

   localparam int unsigned ERR_ENC      = 0;
   localparam int unsigned ERR_CONFLICT = 1;
   localparam int unsigned ERR_SEQ      = 2;
   localparam int unsigned ERR_YEL      = 3;
   localparam int unsigned ERR_CLR      = 4;
   localparam int unsigned ERR_SPUR     = 5;
   localparam int unsigned ERR_STARVE   = 6;

   // True only for one of the three defined colours.
   function automatic logic is_legal(input light_t l);
      return (l == RED) || (l == YEL) || (l == GRN);
   endfunction

endpackage

// File: rtl/traffic_light_monitor_light_track.sv
// Per-road light tracker: remembers the previous colour, counts how long
// the current colour has been shown and decodes the colour transition.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   armed             high once the first post-reset sample is captured
//   light             current light value for this road
//   prev              light value sampled on the previous edge
//   dwell             cycles the previous colour has been shown (saturating)
//   g2y_c/y2r_c/r2g_c legal transition strobes (combinational)
//   illegal_change_c  colour changed along a non-legal edge (combinational)
//   illegal_c         current value is not a legal encoding (combinational)
module light_track
   import traffic_pkg::*;
#(
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               armed,
   input  logic [2:0]         light,
   output logic [2:0]         prev,
   output logic [DWELL_W-1:0] dwell,
   output logic               g2y_c,
   output logic               y2r_c,
   output logic               r2g_c,
   output logic               illegal_change_c,
   output logic               illegal_c
);

   logic changed;

   // Transition decode against the stored previous sample.
   always_comb begin
      changed          = (light != prev);
      g2y_c            = (prev == GRN) && (light == YEL);
      y2r_c            = (prev == YEL) && (light == RED);
      r2g_c            = (prev == RED) && (light == GRN);
      illegal_change_c = changed && !(g2y_c || y2r_c || r2g_c);
      illegal_c        = !is_legal(light);
   end

   // Previous-light capture and dwell counting; the arming cycle seeds
   // the dwell with the one cycle the captured colour has been seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev  <= '0;
         dwell <= '0;
      end else begin
         prev <= light;
         if (!armed || changed) begin
            dwell <= DWELL_W'(1);
         end else if (dwell != '1) begin
            dwell <= dwell + 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for the traffic-light controller outputs.
// Flags encoding, conflict, sequencing, yellow dwell, all-red clearance,
// spurious farm grants and farm starvation; keeps grant/wait statistics.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   light_highway    highway light (RED/YEL/GRN one-hot)
//   light_farm       farm-road light
//   sensor           farm-road vehicle sensor
//   err_flags        sticky error bits, index = error code
//   err_pulse        one-cycle pulse when any error bit is newly set
//   first_err_valid  first error since reset has been recorded
//   first_err_code   code of that first error (lowest index on ties)
//   farm_grants      saturating count of farm RED->GRN transitions
//   max_wait         longest sensor-high-while-farm-red interval
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned YEL_CYC  = 3,
   parameter int unsigned CLR_CYC  = 2,
   parameter int unsigned WAIT_MAX = 64,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            light_highway,
   input  logic [2:0]            light_farm,
   input  logic                  sensor,
   output logic [NUM_ERR-1:0]    err_flags,
   output logic                  err_pulse,
   output logic                  first_err_valid,
   output logic [ERR_CODE_W-1:0] first_err_code,
   output logic [CNT_W-1:0]      farm_grants,
   output logic [CNT_W-1:0]      max_wait
);

   logic                  armed;
   logic [CNT_W-1:0]      allred_cnt;
   logic [CNT_W-1:0]      wait_cnt;
   logic                  req_pending;

   logic [2:0]            hw_prev, fm_prev;
   logic [CNT_W-1:0]      hw_dwell, fm_dwell;
   logic                  hw_g2y, hw_y2r, hw_r2g, hw_bad_chg, hw_ill;
   logic                  fm_g2y, fm_y2r, fm_r2g, fm_bad_chg, fm_ill;

   logic                  hw_seq_c, fm_seq_c;
   logic                  hw_yel_exit_c, fm_yel_exit_c;
   logic                  farm_waiting_c;
   logic [NUM_ERR-1:0]    err_now_c;
   logic [ERR_CODE_W-1:0] err_code_c;

   light_track #(.DWELL_W(CNT_W)) u_highway (
      .clk              (clk),
      .rst              (rst),
      .armed            (armed),
      .light            (light_highway),
      .prev             (hw_prev),
      .dwell            (hw_dwell),
      .g2y_c            (hw_g2y),
      .y2r_c            (hw_y2r),
      .r2g_c            (hw_r2g),
      .illegal_change_c (hw_bad_chg),
      .illegal_c        (hw_ill)
   );

   light_track #(.DWELL_W(CNT_W)) u_farm (
      .clk              (clk),
      .rst              (rst),
      .armed            (armed),
      .light            (light_farm),
      .prev             (fm_prev),
      .dwell            (fm_dwell),
      .g2y_c            (fm_g2y),
      .y2r_c            (fm_y2r),
      .r2g_c            (fm_r2g),
      .illegal_change_c (fm_bad_chg),
      .illegal_c        (fm_ill)
   );

   // Error detection; an illegal current encoding masks the per-road
   // sequencing, dwell and clearance checks for that road.
   always_comb begin
      hw_seq_c       = (light_highway != hw_prev) && !(hw_g2y || hw_y2r || hw_r2g);
      fm_seq_c       = (light_farm != fm_prev) && !(fm_g2y || fm_y2r || fm_r2g);
      hw_yel_exit_c  = hw_y2r || (hw_bad_chg && (hw_prev == YEL));
      fm_yel_exit_c  = fm_y2r || (fm_bad_chg && (fm_prev == YEL));
      farm_waiting_c = sensor && (light_farm == RED);
      err_now_c      = '0;
      if (armed) begin
         err_now_c[ERR_ENC]      = hw_ill || fm_ill;
         err_now_c[ERR_CONFLICT] = (light_highway != RED) && (light_farm != RED);
         err_now_c[ERR_SEQ]      = (!hw_ill && hw_seq_c) || (!fm_ill && fm_seq_c);
         err_now_c[ERR_YEL]      = (!hw_ill && hw_yel_exit_c && (hw_dwell != CNT_W'(YEL_CYC))) ||
                                   (!fm_ill && fm_yel_exit_c && (fm_dwell != CNT_W'(YEL_CYC)));
         err_now_c[ERR_CLR]      = (hw_r2g || fm_r2g) && (allred_cnt < CNT_W'(CLR_CYC));
         err_now_c[ERR_SPUR]     = fm_r2g && !req_pending;
         err_now_c[ERR_STARVE]   = (wait_cnt == CNT_W'(WAIT_MAX));
      end
   end

   // Lowest-index active error wins the first-error code.
   always_comb begin
      err_code_c = '0;
      for (int i = int'(NUM_ERR) - 1; i >= 0; i--) begin
         if (err_now_c[i]) begin
            err_code_c = ERR_CODE_W'(i);
         end
      end
   end

   // Error register, statistics and protocol-tracking state.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed           <= 1'b0;
         allred_cnt      <= '0;
         wait_cnt        <= '0;
         req_pending     <= 1'b0;
         err_flags       <= '0;
         err_pulse       <= 1'b0;
         first_err_valid <= 1'b0;
         first_err_code  <= '0;
         farm_grants     <= '0;
         max_wait        <= '0;
      end else if (!armed) begin
         armed     <= 1'b1;
         err_pulse <= 1'b0;
      end else begin
         err_flags <= err_flags | err_now_c;
         err_pulse <= |(err_now_c & ~err_flags);
         if (!first_err_valid && (|err_now_c)) begin
            first_err_valid <= 1'b1;
            first_err_code  <= err_code_c;
         end

         if ((light_highway == RED) && (light_farm == RED)) begin
            if (allred_cnt != '1) allred_cnt <= allred_cnt + 1'b1;
         end else begin
            allred_cnt <= '0;
         end

         // A grant consumes the pending request; a one-cycle sensor pulse suffices.
         if (fm_r2g) begin
            req_pending <= 1'b0;
         end else if (farm_waiting_c) begin
            req_pending <= 1'b1;
         end

         // Wait interval is folded into max_wait when it ends.
         if (farm_waiting_c) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
            if (wait_cnt > max_wait) max_wait <= wait_cnt;
         end

         if (fm_r2g && (farm_grants != '1)) begin
            farm_grants <= farm_grants + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (WAIT_MAX = 8).
module tb_traffic_light_monitor;
   import traffic_pkg::*;

   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             rst;
   logic [2:0]       light_highway;
   logic [2:0]       light_farm;
   logic             sensor;
   logic [6:0]       err_flags;
   logic             err_pulse;
   logic             first_err_valid;
   logic [2:0]       first_err_code;
   logic [CNT_W-1:0] farm_grants;
   logic [CNT_W-1:0] max_wait;

   int n_cmp = 0;
   int n_bad = 0;

   traffic_light_monitor #(
      .YEL_CYC  (3),
      .CLR_CYC  (2),
      .WAIT_MAX (8),
      .CNT_W    (CNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .light_highway   (light_highway),
      .light_farm      (light_farm),
      .sensor          (sensor),
      .err_flags       (err_flags),
      .err_pulse       (err_pulse),
      .first_err_valid (first_err_valid),
      .first_err_code  (first_err_code),
      .farm_grants     (farm_grants),
      .max_wait        (max_wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic drive(input logic [2:0] hw, input logic [2:0] fm, input logic s);
      light_highway = hw;
      light_farm    = fm;
      sensor        = s;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Two reset cycles, then the arming edge.
   task automatic restart(input logic [2:0] hw, input logic [2:0] fm);
      rst = 1'b1;
      drive(hw, fm, 1'b0);
      ticks(2);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      logic [2:0] bad_enc;
      bad_enc = 3'b011;

      // Test 1: legal full cycle
      rst = 1'b1;
      drive(GRN, RED, 1'b0);
      ticks(4);
      chk("rst_flags", 32'(err_flags), 32'h0);
      chk("rst_pulse", 32'(err_pulse), 32'h0);
      chk("rst_fvalid", 32'(first_err_valid), 32'h0);
      chk("rst_fcode", 32'(first_err_code), 32'h0);
      chk("rst_grants", 32'(farm_grants), 32'h0);
      chk("rst_maxwait", 32'(max_wait), 32'h0);
      rst = 1'b0;
      tick();
      ticks(5);
      drive(GRN, RED, 1'b1);
      tick();
      drive(YEL, RED, 1'b1);
      ticks(3);
      drive(RED, RED, 1'b1);
      ticks(2);
      drive(RED, GRN, 1'b0);
      tick();
      chk("t1_grants_at_grant", 32'(farm_grants), 32'h1);
      chk("t1_maxwait_at_grant", 32'(max_wait), 32'h6);
      ticks(4);
      drive(RED, YEL, 1'b0);
      ticks(3);
      drive(RED, RED, 1'b0);
      ticks(2);
      chk("t1_flags", 32'(err_flags), 32'h0);
      chk("t1_grants", 32'(farm_grants), 32'h1);
      chk("t1_maxwait", 32'(max_wait), 32'h6);
      chk("t1_fvalid", 32'(first_err_valid), 32'h0);

      // Test 2: conflict then illegal encoding
      restart(GRN, GRN);
      chk("t2_armed_clean", 32'(err_flags), 32'h0);
      tick();
      chk("t2_conf_flags", 32'(err_flags), 32'h02);
      chk("t2_conf_pulse", 32'(err_pulse), 32'h1);
      chk("t2_conf_fvalid", 32'(first_err_valid), 32'h1);
      chk("t2_conf_fcode", 32'(first_err_code), 32'h1);
      tick();
      chk("t2_hold_pulse", 32'(err_pulse), 32'h0);
      drive(bad_enc, GRN, 1'b0);
      tick();
      chk("t2_enc_flags", 32'(err_flags), 32'h03);
      chk("t2_enc_pulse", 32'(err_pulse), 32'h1);
      chk("t2_enc_fcode", 32'(first_err_code), 32'h1);
      tick();
      chk("t2_end_pulse", 32'(err_pulse), 32'h0);
      chk("t2_end_flags", 32'(err_flags), 32'h03);

      // Test 3a: short yellow
      restart(GRN, RED);
      tick();
      drive(YEL, RED, 1'b0);
      ticks(2);
      chk("t3a_pre_flags", 32'(err_flags), 32'h0);
      drive(RED, RED, 1'b0);
      tick();
      chk("t3a_flags", 32'(err_flags), 32'h08);
      chk("t3a_fcode", 32'(first_err_code), 32'h3);

      // Test 3b: green straight to red
      restart(GRN, RED);
      tick();
      drive(RED, RED, 1'b0);
      tick();
      chk("t3b_flags", 32'(err_flags), 32'h04);
      chk("t3b_fcode", 32'(first_err_code), 32'h2);

      // Test 4: short clearance and spurious grant
      restart(GRN, RED);
      tick();
      drive(YEL, RED, 1'b0);
      ticks(3);
      drive(RED, RED, 1'b0);
      tick();
      chk("t4_pre_flags", 32'(err_flags), 32'h0);
      drive(RED, GRN, 1'b0);
      tick();
      chk("t4_flags", 32'(err_flags), 32'h30);
      chk("t4_pulse", 32'(err_pulse), 32'h1);
      chk("t4_fcode", 32'(first_err_code), 32'h4);
      chk("t4_grants", 32'(farm_grants), 32'h1);

      // Test 5: starvation, sensor held high for 20 cycles
      restart(GRN, RED);
      drive(GRN, RED, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk($sformatf("t5_flags_c%0d", i), 32'(err_flags), (i >= 9) ? 32'h40 : 32'h0);
         chk($sformatf("t5_pulse_c%0d", i), 32'(err_pulse), (i == 9) ? 32'h1 : 32'h0);
      end
      chk("t5_maxwait_held", 32'(max_wait), 32'h0);
      drive(GRN, RED, 1'b0);
      tick();
      chk("t5_maxwait", 32'(max_wait), 32'd20);
      chk("t5_fcode", 32'(first_err_code), 32'h6);

      // Test 6: reset mid-operation
      restart(GRN, GRN);
      tick();
      chk("t6_err_flags", 32'(err_flags), 32'h02);
      drive(GRN, RED, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_flags", 32'(err_flags), 32'h0);
      chk("t6_rst_pulse", 32'(err_pulse), 32'h0);
      chk("t6_rst_fvalid", 32'(first_err_valid), 32'h0);
      chk("t6_rst_fcode", 32'(first_err_code), 32'h0);
      chk("t6_rst_grants", 32'(farm_grants), 32'h0);
      chk("t6_rst_maxwait", 32'(max_wait), 32'h0);
      tick();
      chk("t6_arm_flags", 32'(err_flags), 32'h0);
      tick();
      drive(YEL, RED, 1'b1);
      ticks(3);
      drive(RED, RED, 1'b1);
      ticks(2);
      drive(RED, GRN, 1'b0);
      ticks(2);
      chk("t6_legal_flags", 32'(err_flags), 32'h0);
      chk("t6_legal_pulse", 32'(err_pulse), 32'h0);
      chk("t6_legal_grants", 32'(farm_grants), 32'h1);
      chk("t6_legal_maxwait", 32'(max_wait), 32'h5);
      chk("t6_legal_fvalid", 32'(first_err_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
